// File: rtl/rv32i_regfile_sequencer.sv
// ---------------------------------------------------------------------------
// rv32i_regfile_sequencer
//
// Sequences a 16-bit dual-port BRAM that holds the 32 x 32-bit RV32I register
// file. Every 32-bit access is split into a low and a high half-word access.
// Operand reads (rs1/rs2) and rd writebacks run concurrently on the BRAM read
// and write ports. Writes that are still in flight, or that arrive while a
// read is being sequenced, are forwarded into the operand response.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_req_valid/o_req_ready  operand read request handshake
//   i_rs1_addr, i_rs2_addr   source register indices
//   o_rsp_valid/i_rsp_ready  operand response handshake
//   o_rs1_data, o_rs2_data   operand values, stable while o_rsp_valid is high
//   i_wr_valid/o_wr_ready    writeback handshake
//   i_wr_addr, i_wr_data     writeback destination and value
//   o_bram_ren/raddr         BRAM read port (data returns next cycle)
//   i_bram_rdata             BRAM read data
//   o_bram_wen/waddr/wdata   BRAM write port
//
// BRAM address for register r, half h: {2'b00, h, r}; the high half uses
// HI_BANK in bit 5, the low half uses 0.
// ---------------------------------------------------------------------------
module rv32i_regfile_sequencer #(
  parameter logic HI_BANK = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [4:0]  i_wr_addr,
  input  logic [31:0] i_wr_data,
  output logic        o_bram_ren,
  output logic [7:0]  o_bram_raddr,
  input  logic [15:0] i_bram_rdata,
  output logic        o_bram_wen,
  output logic [7:0]  o_bram_waddr,
  output logic [15:0] o_bram_wdata
);

  typedef enum logic [2:0] {
    R_IDLE, R_S1L, R_S1H, R_S2L, R_S2H, R_CAP, R_RSP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE, W_LO, W_HI
  } wr_state_t;

  rd_state_t rd_state_q, rd_state_d;
  wr_state_t wr_state_q, wr_state_d;

  // Index 0 is rs1, index 1 is rs2.
  logic [1:0][4:0]  rs_addr_q, rs_addr_d;
  logic [1:0]       fwd_q, fwd_d;
  logic [1:0][31:0] fwd_data_q, fwd_data_d;

  logic [15:0] rs1_lo_q, rs1_lo_d;
  logic [15:0] rs1_hi_q, rs1_hi_d;
  logic [15:0] rs2_lo_q, rs2_lo_d;
  logic [31:0] rs1_data_q, rs1_data_d;
  logic [31:0] rs2_data_q, rs2_data_d;

  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic            req_acc;
  logic            wr_acc;
  logic            rd_window;
  logic            wr_busy;
  logic [1:0][4:0] new_addr;

  function automatic logic [7:0] bram_addr(input logic [4:0] reg_idx, input logic hi);
    bram_addr = {2'b00, (hi ? HI_BANK : 1'b0), reg_idx};
  endfunction

  assign req_acc   = i_req_valid && (rd_state_q == R_IDLE);
  assign wr_acc    = i_wr_valid && (wr_state_q != W_LO);
  assign wr_busy   = (wr_state_q != W_IDLE);
  // Writes accepted anywhere from the first BRAM read up to the capture cycle
  // may land in BRAM too late to be seen, so they are forwarded.
  assign rd_window = (rd_state_q == R_S1L) || (rd_state_q == R_S1H) ||
                     (rd_state_q == R_S2L) || (rd_state_q == R_S2H) ||
                     (rd_state_q == R_CAP);
  assign new_addr[0] = i_rs1_addr;
  assign new_addr[1] = i_rs2_addr;

  assign o_req_ready = (rd_state_q == R_IDLE);
  assign o_rsp_valid = (rd_state_q == R_RSP);
  assign o_wr_ready  = (wr_state_q != W_LO);
  assign o_rs1_data  = rs1_data_q;
  assign o_rs2_data  = rs2_data_q;

  // Forwarding flags. A write accepted in the same cycle is newer than the
  // latched in-flight write, so it takes priority at read acceptance.
  always_comb begin
    fwd_d      = fwd_q;
    fwd_data_d = fwd_data_q;
    for (int i = 0; i < 2; i++) begin
      if (req_acc) begin
        fwd_d[i] = 1'b0;
        if (new_addr[i] != 5'd0) begin
          if (wr_acc && (i_wr_addr == new_addr[i])) begin
            fwd_d[i]      = 1'b1;
            fwd_data_d[i] = i_wr_data;
          end else if (wr_busy && (wr_addr_q == new_addr[i])) begin
            fwd_d[i]      = 1'b1;
            fwd_data_d[i] = wr_data_q;
          end
        end
      end else if (rd_window && wr_acc && (rs_addr_q[i] != 5'd0) &&
                   (i_wr_addr == rs_addr_q[i])) begin
        fwd_d[i]      = 1'b1;
        fwd_data_d[i] = i_wr_data;
      end
    end
  end

  // Read sequencer: four half-word reads, then assemble the response.
  always_comb begin
    rd_state_d   = rd_state_q;
    rs_addr_d    = rs_addr_q;
    rs1_lo_d     = rs1_lo_q;
    rs1_hi_d     = rs1_hi_q;
    rs2_lo_d     = rs2_lo_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    o_bram_ren   = 1'b0;
    o_bram_raddr = 8'h00;
    case (rd_state_q)
      R_IDLE: begin
        if (i_req_valid) begin
          rs_addr_d  = new_addr;
          rd_state_d = R_S1L;
        end
      end
      R_S1L: begin
        o_bram_ren   = 1'b1;
        o_bram_raddr = bram_addr(rs_addr_q[0], 1'b0);
        rd_state_d   = R_S1H;
      end
      R_S1H: begin
        o_bram_ren   = 1'b1;
        o_bram_raddr = bram_addr(rs_addr_q[0], 1'b1);
        rs1_lo_d     = i_bram_rdata;
        rd_state_d   = R_S2L;
      end
      R_S2L: begin
        o_bram_ren   = 1'b1;
        o_bram_raddr = bram_addr(rs_addr_q[1], 1'b0);
        rs1_hi_d     = i_bram_rdata;
        rd_state_d   = R_S2H;
      end
      R_S2H: begin
        o_bram_ren   = 1'b1;
        o_bram_raddr = bram_addr(rs_addr_q[1], 1'b1);
        rs2_lo_d     = i_bram_rdata;
        rd_state_d   = R_CAP;
      end
      R_CAP: begin
        // The rs2 high half arrives this cycle and is used directly. fwd_d is
        // used so that a write accepted in this very cycle is still seen.
        if (rs_addr_q[0] == 5'd0) begin
          rs1_data_d = 32'h0;
        end else if (fwd_d[0]) begin
          rs1_data_d = fwd_data_d[0];
        end else begin
          rs1_data_d = {rs1_hi_q, rs1_lo_q};
        end
        if (rs_addr_q[1] == 5'd0) begin
          rs2_data_d = 32'h0;
        end else if (fwd_d[1]) begin
          rs2_data_d = fwd_data_d[1];
        end else begin
          rs2_data_d = {i_bram_rdata, rs2_lo_q};
        end
        rd_state_d = R_RSP;
      end
      R_RSP: begin
        if (i_rsp_ready) begin
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write sequencer: low half then high half. Accepting in W_HI chains the
  // next write straight into W_LO. x0 completes its handshake without wen.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    o_bram_wen   = 1'b0;
    o_bram_waddr = 8'h00;
    o_bram_wdata = 16'h0000;
    if (wr_acc) begin
      wr_addr_d = i_wr_addr;
      wr_data_d = i_wr_data;
    end
    case (wr_state_q)
      W_IDLE: begin
        if (i_wr_valid) begin
          wr_state_d = W_LO;
        end
      end
      W_LO: begin
        o_bram_wen   = (wr_addr_q != 5'd0);
        o_bram_waddr = bram_addr(wr_addr_q, 1'b0);
        o_bram_wdata = wr_data_q[15:0];
        wr_state_d   = W_HI;
      end
      W_HI: begin
        o_bram_wen   = (wr_addr_q != 5'd0);
        o_bram_waddr = bram_addr(wr_addr_q, 1'b1);
        o_bram_wdata = wr_data_q[31:16];
        wr_state_d   = i_wr_valid ? W_LO : W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_state_q <= R_IDLE;
      wr_state_q <= W_IDLE;
      rs_addr_q  <= '0;
      fwd_q      <= '0;
      fwd_data_q <= '0;
      rs1_lo_q   <= 16'h0;
      rs1_hi_q   <= 16'h0;
      rs2_lo_q   <= 16'h0;
      rs1_data_q <= 32'h0;
      rs2_data_q <= 32'h0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 32'h0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rs_addr_q  <= rs_addr_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      rs1_lo_q   <= rs1_lo_d;
      rs1_hi_q   <= rs1_hi_d;
      rs2_lo_q   <= rs2_lo_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_rv32i_regfile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rv32i_regfile_sequencer
//
// Self-checking bench for rv32i_regfile_sequencer. A behavioural BRAM sits on
// the DUT ports. A monitor keeps an architectural register array updated at
// every accepted writeback and expects each read response to equal that
// array as it stood five cycles after request acceptance. It also checks the
// BRAM port activity cycle by cycle. Table vectors, hand-written corner cases
// and a randomized phase drive the DUT.
// ---------------------------------------------------------------------------
module tb_rv32i_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'h0;
  logic        bram_ren;
  logic [7:0]  bram_raddr;
  logic [15:0] bram_rdata = 16'h0;
  logic        bram_wen;
  logic [7:0]  bram_waddr;
  logic [15:0] bram_wdata;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int wen_cnt = 0;

  logic        mem_clr = 1'b1;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = 8'h0;
  logic [15:0] poke_data = 16'h0;
  logic [15:0] mem [256];

  rv32i_regfile_sequencer #(.HI_BANK(1'b1)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_rs1_addr  (rs1),
    .i_rs2_addr  (rs2),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rs1_data  (rs1_data),
    .o_rs2_data  (rs2_data),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_bram_ren  (bram_ren),
    .o_bram_raddr(bram_raddr),
    .i_bram_rdata(bram_rdata),
    .o_bram_wen  (bram_wen),
    .o_bram_waddr(bram_waddr),
    .o_bram_wdata(bram_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bram_wen) wen_cnt <= wen_cnt + 1;

  // Behavioural BRAM: read-before-write, data one cycle after ren.
  // x0 locations hold junk so that forcing x0 to zero is observable.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0;
      mem[8'h00] <= 16'hBAD0;
      mem[8'h20] <= 16'hBAD1;
    end else begin
      if (poke_en) mem[poke_addr] <= poke_data;
      if (bram_wen) mem[bram_waddr] <= bram_wdata;
    end
    if (bram_ren) bram_rdata <= mem[bram_raddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // ---------------- reference monitor ----------------
  typedef struct packed {
    logic        v;
    logic [7:0]  a;
    logic [15:0] d;
  } wexp_t;

  logic [31:0] m_regs [32];
  wexp_t       e0, e1, e2;
  bit          m_pend;
  bit          m_prev_wacc;
  int          m_tacc;
  int          k;
  logic [4:0]  m_r1, m_r2;
  logic [31:0] m_x1, m_x2;
  logic [7:0]  m_ea;

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    e0 = '0; e1 = '0; e2 = '0;
    m_pend = 1'b0; m_prev_wacc = 1'b0; m_tacc = 0;
    m_r1 = 5'd0; m_r2 = 5'd0; m_x1 = 32'h0; m_x2 = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pend = 1'b0; m_prev_wacc = 1'b0;
        e0 = '0; e1 = '0; e2 = '0;
      end else begin
        // write side: ready drops for exactly the cycle after an acceptance
        chk("wr_ready", 32'(wr_ready), 32'(!m_prev_wacc));
        chk("bram_wen", 32'(bram_wen), 32'(e0.v));
        if (e0.v) begin
          chk("bram_waddr", 32'(bram_waddr), 32'(e0.a));
          chk("bram_wdata", 32'(bram_wdata), 32'(e0.d));
        end
        m_prev_wacc = wr_valid && wr_ready;
        if (m_prev_wacc) begin
          if (wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
          e1 = {wr_addr != 5'd0, 3'b000, wr_addr, wr_data[15:0]};
          e2 = {wr_addr != 5'd0, 3'b001, wr_addr, wr_data[31:16]};
        end
        e0 = e1; e1 = e2; e2 = '0;

        // read side
        if (m_pend) begin
          k = cyc - m_tacc;
          chk("req_ready_busy", 32'(req_ready), 32'd0);
          if (k >= 1 && k <= 4) begin
            case (k)
              1:       m_ea = {3'b000, m_r1};
              2:       m_ea = {3'b001, m_r1};
              3:       m_ea = {3'b000, m_r2};
              default: m_ea = {3'b001, m_r2};
            endcase
            chk("bram_ren", 32'(bram_ren), 32'd1);
            chk("bram_raddr", 32'(bram_raddr), 32'(m_ea));
          end else begin
            chk("bram_ren_off", 32'(bram_ren), 32'd0);
          end
          if (k == 5) begin
            m_x1 = m_regs[m_r1];
            m_x2 = m_regs[m_r2];
          end
          if (k < 6) begin
            chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
          end else begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_rs1", rs1_data, m_x1);
            chk("rsp_rs2", rs2_data, m_x2);
            if (rsp_ready) m_pend = 1'b0;
          end
        end else begin
          chk("req_ready_idle", 32'(req_ready), 32'd1);
          chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
          chk("bram_ren_idle", 32'(bram_ren), 32'd0);
          if (req_valid) begin
            m_pend = 1'b1;
            m_tacc = cyc;
            m_r1 = rs1;
            m_r2 = rs2;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    smp;
    chk("wr_accept", 32'(wr_ready), 32'd1);
    step;
    wr_valid = 1'b0;
  endtask

  // Called in the request cycle T with req_valid already driven.
  task automatic finish_read(input string nm, input logic [31:0] x1, input logic [31:0] x2);
    smp;
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    step;
    req_valid = 1'b0;
    wr_valid  = 1'b0;
    repeat (5) step;
    smp;
    chk({nm, " rsp_valid@T+6"}, 32'(rsp_valid), 32'd1);
    chk({nm, " rs1"}, rs1_data, x1);
    chk({nm, " rs2"}, rs2_data, x2);
    step;
  endtask

  task automatic do_read(input string nm, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] x1, input logic [31:0] x2);
    req_valid = 1'b1; rs1 = a1; rs2 = a2;
    finish_read(nm, x1, x2);
  endtask

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] x1;
    logic [31:0] x2;
    int          nw;
  } vec_t;

  vec_t vt [5];
  int   wc0;

  initial begin
    vt[0] = '{5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        2};
    vt[1] = '{5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 0};
    vt[2] = '{5'd31, 32'hFFFF0001, 5'd31, 5'd5,  32'hFFFF0001, 32'hDEADBEEF, 2};
    vt[3] = '{5'd5,  32'hCAFEF00D, 5'd31, 5'd5,  32'hFFFF0001, 32'hCAFEF00D, 2};
    vt[4] = '{5'd16, 32'h80000000, 5'd16, 5'd16, 32'h80000000, 32'h80000000, 2};

    // reset
    repeat (3) step;
    rst = 1'b0;
    mem_clr = 1'b0;
    smp;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset wr_ready", 32'(wr_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset bram_ren", 32'(bram_ren), 32'd0);
    chk("reset bram_wen", 32'(bram_wen), 32'd0);
    chk("reset rs1_data", rs1_data, 32'h0);
    chk("reset rs2_data", rs2_data, 32'h0);
    step;

    // table: write, idle 4, read back
    for (int v = 0; v < 5; v++) begin
      wc0 = wen_cnt;
      do_write(vt[v].wa, vt[v].wd);
      repeat (4) step;
      chk($sformatf("vec%0d wen_pulses", v), 32'(wen_cnt - wc0), 32'(vt[v].nw));
      do_read($sformatf("vec%0d", v), vt[v].r1, vt[v].r2, vt[v].x1, vt[v].x2);
      $display("vec%0d: wr x%0d=%h, rd x%0d/x%0d -> %h/%h", v, vt[v].wa, vt[v].wd,
               vt[v].r1, vt[v].r2, rs1_data, rs2_data);
    end

    // same-cycle write forwarding with junk in BRAM for x7
    poke_en = 1'b1; poke_addr = 8'h07; poke_data = 16'h5A5A;
    step;
    poke_addr = 8'h27; poke_data = 16'hC3C3;
    step;
    poke_en = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h11112222;
    req_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd7;
    finish_read("samecycle_fwd", 32'h11112222, 32'h11112222);
    $display("samecycle_fwd: x7/x7 -> %h/%h", rs1_data, rs2_data);
    repeat (2) step;

    // two writes to x3 while a read of x3 is in flight; the later one wins
    req_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd4;
    smp;
    chk("inflight req_ready", 32'(req_ready), 32'd1);
    step;                                   // T+1
    req_valid = 1'b0;
    step;                                   // T+2 (R_S1H)
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    smp;
    chk("inflight wr1 ready", 32'(wr_ready), 32'd1);
    step;                                   // T+3
    wr_valid = 1'b0;
    step;                                   // T+4
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h0F0F0F0F;
    smp;
    chk("inflight wr2 ready", 32'(wr_ready), 32'd1);
    step;                                   // T+5
    wr_valid = 1'b0;
    step;                                   // T+6
    smp;
    chk("inflight rsp_valid", 32'(rsp_valid), 32'd1);
    chk("inflight rs1", rs1_data, 32'h0F0F0F0F);
    chk("inflight rs2", rs2_data, 32'h0);
    $display("inflight_fwd: x3/x4 -> %h/%h", rs1_data, rs2_data);
    step;
    repeat (3) step;

    // back-to-back writes x1, x2
    wr_valid = 1'b1; wr_addr = 5'd1; wr_data = 32'h0101AAAA;
    smp;
    chk("b2b wr1 ready", 32'(wr_ready), 32'd1);
    step;                                   // c+1: W_LO
    wr_addr = 5'd2; wr_data = 32'h0202BBBB;
    smp;
    chk("b2b ready_in_lo", 32'(wr_ready), 32'd0);
    chk("b2b wen1", 32'(bram_wen), 32'd1);
    chk("b2b waddr1", 32'(bram_waddr), 32'h01);
    chk("b2b wdata1", 32'(bram_wdata), 32'hAAAA);
    step;                                   // c+2: W_HI, x2 accepted
    smp;
    chk("b2b ready_in_hi", 32'(wr_ready), 32'd1);
    chk("b2b wen2", 32'(bram_wen), 32'd1);
    chk("b2b waddr2", 32'(bram_waddr), 32'h21);
    chk("b2b wdata2", 32'(bram_wdata), 32'h0101);
    step;                                   // c+3
    wr_valid = 1'b0;
    smp;
    chk("b2b wen3", 32'(bram_wen), 32'd1);
    chk("b2b waddr3", 32'(bram_waddr), 32'h02);
    chk("b2b wdata3", 32'(bram_wdata), 32'hBBBB);
    step;                                   // c+4
    smp;
    chk("b2b wen4", 32'(bram_wen), 32'd1);
    chk("b2b waddr4", 32'(bram_waddr), 32'h22);
    chk("b2b wdata4", 32'(bram_wdata), 32'h0202);
    $display("b2b: x1,x2 written, wen sequence 01 21 02 22 observed");
    step;
    do_read("b2b readback", 5'd1, 5'd2, 32'h0101AAAA, 32'h0202BBBB);

    // reset in R_S2L while the consumer is stalled
    rsp_ready = 1'b0;
    req_valid = 1'b1; rs1 = 5'd1; rs2 = 5'd2;
    smp;
    step;                                   // T+1
    req_valid = 1'b0;
    step;                                   // T+2
    step;                                   // T+3 (R_S2L)
    rst = 1'b1;
    step;                                   // T+4
    rst = 1'b0;
    smp;
    chk("midreset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset bram_ren", 32'(bram_ren), 32'd0);
    chk("midreset req_ready", 32'(req_ready), 32'd1);
    chk("midreset rs1_data", rs1_data, 32'h0);
    chk("midreset rs2_data", rs2_data, 32'h0);
    rsp_ready = 1'b1;
    step;
    do_read("after reset", 5'd1, 5'd2, 32'h0101AAAA, 32'h0202BBBB);
    $display("midreset: recovered read x1/x2 -> %h/%h", rs1_data, rs2_data);

    // randomized traffic, checked by the monitor
    for (int n = 0; n < 3000; n++) begin
      req_valid = ($urandom_range(0, 2) == 0);
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      wr_valid  = ($urandom_range(0, 1) == 0);
      wr_addr   = 5'($urandom_range(0, 7));
      wr_data   = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      step;
    end
    req_valid = 1'b0;
    wr_valid  = 1'b0;
    rsp_ready = 1'b1;
    repeat (20) step;
    $display("random: 3000 cycles of mixed traffic completed");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_regfile_sequencer.md
Name: rv32i_regfile_sequencer

Overview:
- Controls the 16-bit-wide dual-port iCE40 BRAM that holds the 32 x 32-bit RV32I register file.
- Splits each 32-bit access into a low and a high half-word access and sequences the BRAM ports.
- Returns rs1/rs2 operand pairs to decode/execute over a valid/ready handshake, and accepts rd writebacks on a separate handshake.
- Keeps read data coherent with in-flight writes by forwarding.

Parameters:
- HI_BANK, 1'b1, BRAM address bit 5 that selects the high half-word bank. The low bank uses 0.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset (see Behaviour)
- i_req_valid  in  1  operand read request
- o_req_ready  out  1  read request accepted when high with i_req_valid
- i_rs1_addr  in  5  source register 1
- i_rs2_addr  in  5  source register 2
- o_rsp_valid  out  1  operand response valid
- i_rsp_ready  in  1  consumer accepts response
- o_rs1_data  out  32  rs1 value
- o_rs2_data  out  32  rs2 value
- i_wr_valid  in  1  writeback request
- o_wr_ready  out  1  writeback accepted when high with i_wr_valid
- i_wr_addr  in  5  destination register
- i_wr_data  in  32  writeback value
- o_bram_ren  out  1  BRAM read enable
- o_bram_raddr  out  8  BRAM read address
- i_bram_rdata  in  16  BRAM read data, valid the cycle after ren
- o_bram_wen  out  1  BRAM write enable
- o_bram_waddr  out  8  BRAM write address
- o_bram_wdata  out  16  BRAM write data

Behaviour:
- Reset: i_rst, synchronous, active-high; clock i_clk.
- BRAM address for register r, half h: {2'b00, h, r[4:0]}. h=0 selects [15:0]; h=HI_BANK selects [31:16].
- Reset values:
  - Both FSMs return to IDLE.
  - o_rsp_valid=0, o_bram_ren=0, o_bram_wen=0, o_rs1_data=0, o_rs2_data=0, forward flags cleared.
  - o_req_ready and o_wr_ready are 1 from the first cycle after reset.
  - A write interrupted mid-way by reset may leave that register torn (lo new, hi old). This is accepted behaviour.
- Read FSM states: R_IDLE -> R_S1L -> R_S1H -> R_S2L -> R_S2H -> R_CAP -> R_RSP -> R_IDLE.
  - o_req_ready = (state == R_IDLE).
  - Request accepted in cycle T: addresses latched. o_bram_ren is high in T+1..T+4 with addresses rs1 lo, rs1 hi, rs2 lo, rs2 hi.
  - Half-words are captured in cycles T+2..T+5.
  - o_rsp_valid rises in T+6 and holds with stable data until i_rsp_ready. R_IDLE is re-entered on the following cycle.
  - Minimum request-to-request spacing is 7 cycles.
- Register x0: the BRAM read is still issued, but operand data is forced to 0.
- Write FSM states: W_IDLE -> W_LO -> W_HI.
  - o_wr_ready = (state != W_LO).
  - Write accepted in cycle T: addr/data latched. Cycle T+1: wen, lo half. Cycle T+2: wen, hi half.
  - A write accepted in W_HI goes to W_LO next, allowing back-to-back writes (one every 2 cycles).
- x0 writes: the handshake completes but o_bram_wen stays low for both halves.
- Forwarding, per operand, for a nonzero register only. The latest matching write wins.
  - At read acceptance: if the write FSM is in W_LO/W_HI with a latched addr equal to the operand, or a write is accepted in the same cycle with a matching addr, set fwd and capture that write data.
  - While the read FSM is in R_S1L..R_CAP: any accepted write with a matching addr sets fwd and captures i_wr_data.
  - In R_RSP, writes are not forwarded; the response is frozen.
  - On entering R_RSP, an operand with fwd set uses its forwarded data instead of the BRAM data.
  - rs1 == rs2 is legal; both operands forward identically.
- Reads and writes run concurrently on separate BRAM ports. The sequencer itself raises no port conflict.

Test Plan:
- Write x5=0xDEADBEEF, idle 4 cycles, read rs1=x5, rs2=x0 -> BRAM writes at waddr 0x05 (0xBEEF) then 0x25 (0xDEAD). o_rsp_valid at T+6 with rs1=0xDEADBEEF, rs2=0.
- Write to x0 of 0x12345678 -> o_wr_ready handshake completes, o_bram_wen never asserts. A subsequent read of x0 returns 0.
- Write x7=0x11112222 accepted in the same cycle as a read of rs1=x7, rs2=x7 -> both operands return 0x11112222 (forwarded), independent of BRAM contents.
- Read of x3 in progress (R_S1H); write x3=0xA5A5A5A5, then write x3=0x0F0F0F0F 2 cycles later -> rs1=0x0F0F0F0F.
- Back-to-back writes x1, x2 on consecutive handshake slots -> o_wr_ready low only in W_LO. wen sequence: 0x01, 0x21, 0x02, 0x22 with no gaps.
- Assert i_rst in R_S2L with i_rsp_ready low -> next cycle o_rsp_valid=0, o_bram_ren=0, o_req_ready=1. A new read returns correct data at T+6.
